c_ctrl_pipe: RTL and testbench
==============================

C_CTRL_PIPE -- requirements
Module: c_ctrl_pipe

Interface
REQ-001 Parameter: WIDTH, 16, control-bundle width per stage.
REQ-002 Parameter: STAGES, 3, number of register stages (legal range 1..8).
REQ-003 Parameter: NOP_VALUE, 16'h0010, bundle loaded on reset, flush and bubble; the default sets the OpBSrc bit only.
REQ-004 Parameter: CNT_W, 16, width of the performance counters.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  a decoded instruction is present at the pipe input.
REQ-008 in_data  in  WIDTH  decoded control bundle.
REQ-009 stall  in  STAGES  per-stage hold; bit k holds stage k.
REQ-010 flush  in  STAGES  per-stage kill; bit k kills stage k.
REQ-011 out_valid  out  STAGES  valid flag of each stage.
REQ-012 out_data  out  STAGES*WIDTH  stage k occupies bits [k*WIDTH +: WIDTH].
REQ-013 bubble_cnt  out  CNT_W  count of cycles in which the last stage is invalid.
REQ-014 flush_cnt  out  CNT_W  count of valid instructions killed by flush.
REQ-015 stall_err  out  1  sticky protocol-violation flag.

Function
REQ-016 Stage 0 source is {in_valid, in_data}; the source of stage k>0 is stage k-1.
REQ-017 Per-stage update priority is flush[k], then stall[k], then advance, evaluated at each rising clk.
REQ-018 When flush[k]=1, stage k SHALL load valid=0 and data=NOP_VALUE, regardless of stall[k].
REQ-019 When stall[k]=1 and flush[k]=0, stage k SHALL hold both valid and data.
REQ-020 When advancing with k>0 and stall[k-1]=1 or flush[k-1]=1, stage k SHALL load a bubble (valid=0, data=NOP_VALUE), so held data is never duplicated.
REQ-021 When advancing otherwise, stage k SHALL load its source valid and data.
REQ-022 When advancing with in_valid=0, stage 0 SHALL load data=NOP_VALUE, ignoring in_data.
REQ-023 Latency in_data to stage k is k+1 cycles with no stalls; outputs are driven directly from flops.
REQ-024 stall_err SHALL set on any edge where, for some k<STAGES-1, stall[k]=0, stall[k+1]=1, flush[k+1]=0 and out_valid[k]=1 (stage k would overwrite a held downstream stage).
REQ-025 stall_err is cleared only by reset; the pipe keeps operating per REQ-017..022 after it sets.
REQ-026 bubble_cnt SHALL increment by 1 on each edge where out_valid[STAGES-1]=0, saturating at all-ones.
REQ-027 flush_cnt SHALL add popcount(flush & out_valid) on each edge, saturating at all-ones with no wrap.
REQ-028 Simultaneous flush on several stages SHALL kill each flushed stage independently in the same cycle.

Reset
REQ-029 Reset asserted SHALL immediately force all out_valid=0, all stage data=NOP_VALUE, bubble_cnt=0, flush_cnt=0 and stall_err=0.
REQ-030 Reset mid-stall or mid-flush SHALL discard all in-flight state; the first edge after deassertion behaves per REQ-017.

Structure
REQ-031 The package c_pipe_pkg SHALL hold the NOP_VALUE default, the ctrl bundle field offsets (RegWE_E, RegWE_W, OpBSrc, MemWrite, branch, jump, ExPath, ALUFunc, funct3) and a saturating-add function.
REQ-032 A single sub-module, c_pipe_stage (one valid+data register applying REQ-017..022), SHALL be instantiated STAGES times via generate.
REQ-033 The counters and stall_err logic reside in c_ctrl_pipe top.

Verification
REQ-034 STAGES=3, no stall: in_valid=1 with in_data=16'hA5A5 for 1 cycle -> out_data stage 2 = A5A5 with out_valid[2]=1 exactly 3 cycles later, then NOP_VALUE/valid=0.
REQ-035 stall=3'b001 for 2 cycles with stage 0=16'h1234 valid -> stage 0 holds 1234; stage 1 receives 2 bubbles; after release, 1234 reaches stage 1 on the next edge.
REQ-036 stall[1]=1 and flush[1]=1 together on valid stage 1 -> stage 1 becomes NOP_VALUE/invalid and flush_cnt increments by 1.
REQ-037 flush=3'b111 with all stages valid -> all invalid next cycle, flush_cnt +3; flush_cnt preloaded near 16'hFFFE saturates at FFFF.
REQ-038 stall=3'b010 with stage 0 valid -> stall_err=1 next cycle and stays 1 until reset.
REQ-039 Reset asserted between clock edges during a stall -> outputs clear asynchronously, before the next clk edge.

Source files
------------

// File: rtl/c_pipe_pkg.sv
// Shared definitions for the decoded-control pipeline: bundle layout, NOP
// encoding and a saturating adder for the performance counters.
package c_pipe_pkg;

    // Bit offsets of the fields inside the 16-bit decoded control bundle.
    localparam int REGWE_E_BIT  = 0;
    localparam int REGWE_W_BIT  = 1;
    localparam int MEMWRITE_BIT = 2;
    localparam int BRANCH_BIT   = 3;
    localparam int OPBSRC_BIT   = 4;
    localparam int JUMP_BIT     = 5;
    localparam int EXPATH_LSB   = 6;
    localparam int ALUFUNC_LSB  = 8;
    localparam int FUNCT3_LSB   = 12;

    typedef struct packed {
        logic       spare;
        logic [2:0] funct3;
        logic [3:0] alu_func;
        logic [1:0] ex_path;
        logic       jump;
        logic       op_b_src;
        logic       branch;
        logic       mem_write;
        logic       reg_we_w;
        logic       reg_we_e;
    } ctrl_t;

    // A NOP only selects the immediate operand; every write enable is off.
    localparam logic [15:0] NOP_DEFAULT = 16'(1) << OPBSRC_BIT;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/c_pipe_stage.sv
// One pipeline register (valid + control bundle) with flush > stall > advance
// priority; a killed upstream stage feeds this one a bubble.
module c_pipe_stage
    import c_pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             kill_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // NOTE: defaults first so every branch assigns both next-state signals; no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else if (stall_i) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else if (kill_i || !src_valid_i) begin
            // Upstream is held or killed, or simply empty: never duplicate its data.
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else begin
            valid_d = 1'b1;
            data_d  = src_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/c_ctrl_pipe.sv
// Decoded-control pipeline: STAGES chained stage registers plus bubble/flush
// performance counters and a sticky stall-protocol error flag.
module c_ctrl_pipe
    import c_pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_DEFAULT),
    parameter int               CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES-1:0]       out_valid,
    output logic [STAGES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        flush_cnt,
    output logic                    stall_err
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            c_pipe_stage #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .flush_i     (flush[k]),
                .stall_i     (stall[k]),
                .kill_i      (1'b0),
                .src_valid_i (in_valid),
                .src_data_i  (in_data),
                .valid_o     (out_valid[k]),
                .data_o      (out_data[k*WIDTH +: WIDTH])
            );
        end else begin : g_body
            c_pipe_stage #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .flush_i     (flush[k]),
                .stall_i     (stall[k]),
                .kill_i      (stall[k-1] | flush[k-1]),
                .src_valid_i (out_valid[k-1]),
                .src_data_i  (out_data[(k-1)*WIDTH +: WIDTH]),
                .valid_o     (out_valid[k]),
                .data_o      (out_data[k*WIDTH +: WIDTH])
            );
        end
    end

    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic             stall_err_q,  stall_err_d;
    logic [3:0]       kill_n;
    logic             violation;

    always_comb begin
        violation = 1'b0;
        kill_n    = '0;
        // A moving stage k feeding a held, surviving stage k+1 would overwrite it.
        for (int k = 0; k < STAGES - 1; k++) begin
            violation |= !stall[k] && stall[k+1] && !flush[k+1] && out_valid[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            kill_n += 4'(flush[k] & out_valid[k]);
        end
        bubble_cnt_d = CNT_W'(sat_add(32'(bubble_cnt_q), 32'(!out_valid[STAGES-1]), CNT_MAX));
        flush_cnt_d  = CNT_W'(sat_add(32'(flush_cnt_q), 32'(kill_n), CNT_MAX));
        stall_err_d  = stall_err_q | violation;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_c_ctrl_pipe.sv
// Self-checking bench for c_ctrl_pipe: directed scenarios then random traffic,
// compared against a stage-list reference model; a narrow-counter copy shows saturation.
module tb_c_ctrl_pipe;

    localparam int          S   = 3;
    localparam int          W   = 16;
    localparam logic [15:0] NOP = 16'h0010;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic [S-1:0]    out_valid,   s_out_valid;
    logic [S*W-1:0]  out_data,    s_out_data;
    logic [15:0]     bubble_cnt,  flush_cnt;
    logic [3:0]      s_bubble_cnt, s_flush_cnt;
    logic            stall_err,   s_stall_err;

    c_ctrl_pipe #(.WIDTH(W), .STAGES(S), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt),
        .stall_err  (stall_err)
    );

    c_ctrl_pipe #(.WIDTH(W), .STAGES(S), .NOP_VALUE(NOP), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .bubble_cnt (s_bubble_cnt),
        .flush_cnt  (s_flush_cnt),
        .stall_err  (s_stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a list of stage slots plus plain integer counters.
    bit          mv[S];
    logic [15:0] md[S];
    int unsigned m_bub, m_fl;
    bit          m_err;

    function automatic int unsigned sat(input int unsigned x, input int unsigned max_val);
        return (x > max_val) ? max_val : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            md[k] = NOP;
        end
        m_bub = 0;
        m_fl  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit          ov[S];
        logic [15:0] od[S];
        for (int k = 0; k < S; k++) begin
            ov[k] = mv[k];
            od[k] = md[k];
        end
        for (int k = 0; k < S - 1; k++) begin
            if (!stall[k] && stall[k+1] && !flush[k+1] && ov[k]) m_err = 1'b1;
        end
        if (!ov[S-1]) m_bub++;
        for (int k = 0; k < S; k++) begin
            if (flush[k] && ov[k]) m_fl++;
        end
        for (int k = 0; k < S; k++) begin
            if (flush[k]) begin
                mv[k] = 1'b0;
                md[k] = NOP;
            end else if (stall[k]) begin
                mv[k] = ov[k];
                md[k] = od[k];
            end else if (k > 0 && (stall[k-1] || flush[k-1])) begin
                mv[k] = 1'b0;
                md[k] = NOP;
            end else if (k == 0) begin
                mv[k] = in_valid;
                md[k] = in_valid ? in_data : NOP;
            end else begin
                mv[k] = ov[k-1];
                md[k] = od[k-1];
            end
        end
    endtask

    task automatic compare_all();
        logic [S-1:0]   ev;
        logic [S*W-1:0] ed;
        for (int k = 0; k < S; k++) begin
            ev[k]          = mv[k];
            ed[k*W +: W]   = md[k];
        end
        check("out_valid",    64'(out_valid),    64'(ev));
        check("out_data",     64'(out_data),     64'(ed));
        check("bubble_cnt",   64'(bubble_cnt),   64'(sat(m_bub, 16'hFFFF)));
        check("flush_cnt",    64'(flush_cnt),    64'(sat(m_fl, 16'hFFFF)));
        check("stall_err",    64'(stall_err),    64'(m_err));
        check("sat_valid",    64'(s_out_valid),  64'(ev));
        check("sat_data",     64'(s_out_data),   64'(ed));
        check("sat_bubble",   64'(s_bubble_cnt), 64'(sat(m_bub, 15)));
        check("sat_flush",    64'(s_flush_cnt),  64'(sat(m_fl, 15)));
        check("sat_err",      64'(s_stall_err),  64'(m_err));
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit v, input logic [15:0] d, input logic [S-1:0] st, input logic [S-1:0] fl);
        in_valid = v;
        in_data  = d;
        stall    = st;
        flush    = fl;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(out_valid),  64'(0));
        check({tag, "_data"},  64'(out_data),   64'({NOP, NOP, NOP}));
        check({tag, "_bub"},   64'(bubble_cnt), 64'(0));
        check({tag, "_fl"},    64'(flush_cnt),  64'(0));
        check({tag, "_err"},   64'(stall_err),  64'(0));
    endtask

    int unsigned fl_before;

    initial begin
        reset = 1'b1;
        set_in(1'b0, 16'h0000, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        // Single instruction walks to the last stage in three edges.
        set_in(1'b1, 16'hA5A5, '0, '0);
        step();
        set_in(1'b0, 16'hFFFF, '0, '0);
        step();
        step();
        check("lat_data", 64'(out_data[2*W +: W]), 64'(16'hA5A5));
        check("lat_valid", 64'(out_valid[2]), 64'(1));
        step();
        check("lat_after_data", 64'(out_data[2*W +: W]), 64'(NOP));
        check("lat_after_valid", 64'(out_valid[2]), 64'(0));

        // Stage 0 held for two cycles; stage 1 sees bubbles, then the held word.
        set_in(1'b1, 16'h1234, '0, '0);
        step();
        set_in(1'b0, 16'h0000, 3'b001, '0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_s0", 64'(out_data[0 +: W]), 64'(16'h1234));
            check("hold_s1_valid", 64'(out_valid[1]), 64'(0));
            check("hold_s1_data", 64'(out_data[W +: W]), 64'(NOP));
        end
        set_in(1'b0, 16'h0000, '0, '0);
        step();
        check("release_s1", 64'(out_data[W +: W]), 64'(16'h1234));
        check("release_s1_valid", 64'(out_valid[1]), 64'(1));

        // Flush beats stall on a valid stage 1.
        fl_before = m_fl;
        set_in(1'b0, 16'h0000, 3'b010, 3'b010);
        step();
        check("flush_over_stall_valid", 64'(out_valid[1]), 64'(0));
        check("flush_over_stall_data", 64'(out_data[W +: W]), 64'(NOP));
        check("flush_over_stall_cnt", 64'(flush_cnt), 64'(fl_before + 1));

        // Fill all stages, then kill all three together.
        for (int i = 0; i < S; i++) begin
            set_in(1'b1, 16'(16'h0100 + i), '0, '0);
            step();
        end
        check("full_valid", 64'(out_valid), 64'(3'b111));
        fl_before = m_fl;
        set_in(1'b0, 16'h0000, '0, 3'b111);
        step();
        check("flush_all_valid", 64'(out_valid), 64'(0));
        check("flush_all_cnt", 64'(flush_cnt), 64'(fl_before + 3));

        // Downstream hold while a valid stage 0 advances: sticky error.
        check("err_clear_before", 64'(stall_err), 64'(0));
        set_in(1'b1, 16'hC0DE, '0, '0);
        step();
        set_in(1'b0, 16'h0000, 3'b010, '0);
        step();
        check("err_set", 64'(stall_err), 64'(1));
        set_in(1'b1, 16'h0F0F, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_sticky", 64'(stall_err), 64'(1));
        end

        // Asynchronous reset between edges while stage 0 is stalled.
        set_in(1'b1, 16'hBEEF, '0, '0);
        step();
        set_in(1'b1, 16'h5555, 3'b001, '0);
        step();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_cleared("async_reset");
        reset = 1'b0;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            for (int k = 0; k < S; k++) begin
                stall[k] = ($urandom_range(0, 3) == 0);
                flush[k] = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        if (m_fl >= 15) check("sat_flush_pinned", 64'(s_flush_cnt), 64'(4'hF));
        if (m_bub >= 15) check("sat_bubble_pinned", 64'(s_bubble_cnt), 64'(4'hF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
